uart_rx_8n1: RTL and testbench
==============================

// Module: uart_rx_8n1
// PURPOSE
//   Serial receiver for the z80 system serial port: 8 data bits, no parity, 1 stop bit, LSB first.
//   Line idles high.
//   Deserialises the asynchronous ser_in line into bytes and queues them in a small FIFO.
//   Bytes leave the FIFO over a valid/ready handshake.
//   Sits between the board-level serial input pin and the CPU-side serial peripheral registers.
//   It is the receive counterpart of the system's serial transmit path.
// PARAMETERS
//   CLKS_PER_BIT  417  clk cycles per bit: int'(4 MHz / 9600). Legal range >= 8.
//   FIFO_DEPTH    4    receive FIFO entries. Power of two, >= 2.
// PORTS
//   clk       in   1                         system clock; all logic on posedge
//   rst       in   1                         synchronous, active-high reset
//   ser_in    in   1                         asynchronous serial line, idle high
//   rx_data   out  8                         FIFO head byte (first-word fall-through)
//   rx_valid  out  1                         FIFO not empty
//   rx_ready  in   1                         consumer accepts rx_data; pop when rx_valid & rx_ready
//   rx_level  out  $clog2(FIFO_DEPTH+1)      FIFO occupancy
//   frame_err out  1                         1-cycle pulse: stop bit sampled low
//   overrun   out  1                         1-cycle pulse: completed byte dropped because FIFO full
// BEHAVIOUR
//   Reset:
//   - rx_data=0, rx_valid=0, rx_level=0, frame_err=0, overrun=0.
//   - FSM=IDLE, FIFO empty, synchroniser flops preset to 1.
//   - Reset mid-frame aborts the frame; the partial byte is discarded.
//   Input conditioning:
//   - ser_in passes through a 2-flop synchroniser; "line" below means the synchronised value.
//   - The synchroniser adds 2 cycles of latency.
//   Bit counter:
//   - Counts 0..CLKS_PER_BIT-1.
//   - HALF = CLKS_PER_BIT/2 (integer division).
//   FSM:
//   - IDLE:  line==0 -> START, counter cleared.
//   - START: at count==HALF-1, sample line.
//     - 1 -> false start: IDLE; no pulse, nothing written.
//     - 0 -> DATA, bit index 0, counter cleared.
//   - DATA:  at count==CLKS_PER_BIT-1, shift line into bit[index]; index++.
//     - After bit 7 -> STOP.
//   - STOP:  at count==CLKS_PER_BIT-1, sample line.
//     - 1 -> push byte, return to IDLE that same cycle. No wait for the stop bit end; back-to-back frames are supported.
//     - 0 -> frame_err pulse, byte discarded, -> BREAK.
//   - BREAK: wait for line==1, then IDLE. A held-low break line yields exactly one frame_err.
//   FIFO:
//   - Push lands on the cycle after the stop sample; rx_valid rises then.
//   - rx_data is valid whenever rx_valid=1 and holds stable until popped.
//   - Push with full FIFO: byte dropped, overrun pulse, contents unchanged.
//     - Exception: a pop in the same cycle makes room, so the push succeeds with no overrun.
//   - Simultaneous push and pop (not full): rx_level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - rx_ready while empty is ignored.
//   - frame_err and overrun are never asserted in the same cycle.
// TESTING (bench uses CLKS_PER_BIT=16 unless stated; sender drives ser_in directly)
//   1. Frame 0x55, rx_ready=1.
//      -> rx_valid high 1 cycle, rx_data=0x55.
//      -> rx_level returns to 0; no error pulses.
//   2. ser_in low for 4 cycles, then high.
//      -> FSM returns to IDLE; rx_valid stays 0; frame_err stays 0.
//   3. Frame 0xA5 with stop bit=0; line held low 3 bit times, then high; then frame 0x3C.
//      -> exactly one frame_err pulse; 0xA5 absent.
//      -> 0x3C is received correctly.
//   4. rx_ready=0; frames 0x01..0x05 back-to-back (FIFO_DEPTH=4).
//      -> rx_level=4; one overrun pulse on the 5th frame.
//      -> draining yields 01,02,03,04.
//   5. Assert rst after 3 data bits of 0xFF.
//      -> all outputs 0 next cycle.
//      -> a following frame 0xC3 is received correctly.
//   6. CLKS_PER_BIT=417; frames 0x96, 0x69 sent at bit periods of 408 and 426 cycles (about +/-2% error).
//      -> both bytes received with no errors.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// small first-word-fall-through receive FIFO drained over valid/ready.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ser_in,
  output logic [7:0]                       rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_level,
  output logic                             frame_err,
  output logic                             overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_line;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_frame_err;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;

  logic          w_cnt_last;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;

  // Preset to idle-high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ser_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line     = r_sync2;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_push     = (r_state == S_STOP) && w_cnt_last && w_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_line) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= w_line ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_line;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_line) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_line) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_pop  = rx_ready && (r_level != LVL_ZERO);
  assign w_full = (r_level == LVL_FULL);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
    end
  end

  assign rx_valid  = (r_level != LVL_ZERO);
  assign rx_data   = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_level  = r_level;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: a fast instance (16 clks/bit) for the
// functional cases and a 417 clks/bit instance for baud-tolerance frames.
module tb_uart_rx_8n1;

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;

  logic       ser_in2;
  logic       rx_ready2;
  logic [7:0] rx_data2;
  logic       rx_valid2;
  logic [2:0] rx_level2;
  logic       frame_err2;
  logic       overrun2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q  [$];
  logic [7:0] exp_q2 [$];

  int valid_cycles = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int fe_cnt2 = 0;
  int ov_cnt2 = 0;

  uart_rx_8n1 #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .frame_err(frame_err), .overrun(overrun)
  );

  uart_rx_8n1 #(.CLKS_PER_BIT(417), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .ser_in(ser_in2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .rx_level(rx_level2), .frame_err(frame_err2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 2) ser_in2 = v;
    else            ser_in  = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input int bit_clks, input logic stop);
    set_line(which, 1'b0);
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      wait_clks(bit_clks);
    end
    set_line(which, stop);
    wait_clks(bit_clks);
  endtask

  task automatic wait_empty1(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) wait_clks(1);
    check(name, exp_q.size(), 0);
  endtask

  // Monitors: compare every accepted byte against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)  valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected actual=%02h required=none", rx_data);
        end else begin
          check("sb_data", rx_data, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err2) fe_cnt2++;
      if (overrun2)   ov_cnt2++;
      if (rx_valid2 && rx_ready2) begin
        if (exp_q2.size() == 0) begin
          n_checks++;
          $display("FAIL sb2_unexpected actual=%02h required=none", rx_data2);
        end else begin
          check("sb2_data", rx_data2, exp_q2.pop_front());
        end
      end
    end
  end

  initial begin
    int vc0, fe0, ov0;
    rst = 1'b1;
    ser_in = 1'b1;
    ser_in2 = 1'b1;
    rx_ready = 1'b1;
    rx_ready2 = 1'b1;
    @(posedge clk); #1;
    wait_clks(3);
    check("rst_rx_data",   rx_data,   0);
    check("rst_rx_valid",  rx_valid,  0);
    check("rst_rx_level",  rx_level,  0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun",   overrun,   0);
    rst = 1'b0;
    wait_clks(4);

    // 1: single frame with consumer ready
    vc0 = valid_cycles;
    exp_q.push_back(8'h55);
    send_frame(1, 8'h55, 16, 1'b1);
    wait_clks(20);
    $display("T1 frame 0x55 sent, valid_cycles=%0d", valid_cycles - vc0);
    check("t1_valid_cycles", valid_cycles - vc0, 1);
    check("t1_level", rx_level, 0);
    check("t1_frame_err", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);
    wait_empty1("t1_sb_empty", 50);

    // 2: glitch shorter than half a bit
    vc0 = valid_cycles;
    fe0 = fe_cnt;
    set_line(1, 1'b0);
    wait_clks(4);
    set_line(1, 1'b1);
    wait_clks(40);
    $display("T2 4-cycle glitch, valid_cycles=%0d", valid_cycles - vc0);
    check("t2_no_valid", valid_cycles - vc0, 0);
    check("t2_no_frame_err", fe_cnt - fe0, 0);
    check("t2_level", rx_level, 0);

    // 3: bad stop bit followed by a held break, then a good frame
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(1, 8'hA5, 16, 1'b0);
    wait_clks(32);
    set_line(1, 1'b1);
    wait_clks(16);
    exp_q.push_back(8'h3C);
    send_frame(1, 8'h3C, 16, 1'b1);
    wait_clks(20);
    $display("T3 break then 0x3C, frame_err pulses=%0d", fe_cnt - fe0);
    check("t3_one_frame_err", fe_cnt - fe0, 1);
    check("t3_no_overrun", ov_cnt - ov0, 0);
    wait_empty1("t3_sb_empty", 50);

    // 4: fill the FIFO with the consumer stalled, one byte overruns
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(1, 8'(i), 16, 1'b1);
    end
    wait_clks(10);
    $display("T4 five frames stalled, level=%0d overruns=%0d", rx_level, ov_cnt - ov0);
    check("t4_level_full", rx_level, 4);
    check("t4_one_overrun", ov_cnt - ov0, 1);
    rx_ready = 1'b1;
    wait_empty1("t4_drained", 50);
    check("t4_level_empty", rx_level, 0);

    // 5: reset in the middle of a frame
    rx_ready = 1'b0;
    send_frame(1, 8'h7E, 16, 1'b1);
    wait_clks(10);
    check("t5_level_before", rx_level, 1);
    set_line(1, 1'b0);
    wait_clks(16);
    set_line(1, 1'b1);
    wait_clks(16 * 3 + 5);
    rst = 1'b1;
    wait_clks(1);
    $display("T5 reset mid-frame, level=%0d valid=%0d", rx_level, rx_valid);
    check("t5_rst_rx_data",   rx_data,   0);
    check("t5_rst_rx_valid",  rx_valid,  0);
    check("t5_rst_rx_level",  rx_level,  0);
    check("t5_rst_frame_err", frame_err, 0);
    check("t5_rst_overrun",   overrun,   0);
    rst = 1'b0;
    wait_clks(32);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(1, 8'hC3, 16, 1'b1);
    wait_clks(20);
    wait_empty1("t5_sb_empty", 50);

    // 6: slow instance, sender about 2% fast then 2% slow
    exp_q2.push_back(8'h96);
    exp_q2.push_back(8'h69);
    send_frame(2, 8'h96, 408, 1'b1);
    send_frame(2, 8'h69, 426, 1'b1);
    for (int i = 0; i < 2000 && exp_q2.size() != 0; i++) wait_clks(1);
    $display("T6 baud tolerance frames, pending=%0d", exp_q2.size());
    check("t6_sb_empty", exp_q2.size(), 0);
    check("t6_frame_err", fe_cnt2, 0);
    check("t6_overrun", ov_cnt2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
